axi_wr_master: RTL and testbench

AXI_WR_MASTER -- requirements
Module: axi_wr_master

---
 rtl/axi_wr_master.sv | 109 ++++++++++
 tb/tb_axi_wr_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_master.sv
// AXI write master: one INCR burst at a time, user data streamed straight
// through to the W channel, and the B response reported as a done pulse.
module axi_wr_master #(
    parameter logic [3:0] WR_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic [3:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,
    output logic [31:0] MASTER_WR_DATA,
    output logic [3:0]  MASTER_WR_STRB,
    output logic        MASTER_WR_DATA_LAST,
    output logic        MASTER_WR_DATA_VALID,
    input  logic        MASTER_WR_DATA_READY,
    input  logic [3:0]  MASTER_WR_BACK_ID,
    input  logic [1:0]  MASTER_WR_BACK_RESP,
    input  logic        MASTER_WR_BACK_VALID,
    output logic        MASTER_WR_BACK_READY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [8:0]  cnt;
    logic        done_q;
    logic [1:0]  resp_q;
    logic        in_w;
    logic        beat;
    logic        last;

    assign in_w = (state == S_W);
    assign beat = in_w && wdata_valid && MASTER_WR_DATA_READY;
    assign last = in_w && (cnt == {1'b0, len_q});

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (cmd_valid)            state_nx = S_AW;
            S_AW:   if (MASTER_WR_ADDR_READY) state_nx = S_W;
            S_W:    if (beat && last)         state_nx = S_B;
            S_B:    if (MASTER_WR_BACK_VALID) state_nx = S_IDLE;
            default:                          state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            resp_q <= 2'b00;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                cnt    <= '0;
            end
            if (beat) cnt <= cnt + 9'd1;
            if (state == S_B && MASTER_WR_BACK_VALID) begin
                done_q <= 1'b1;
                // A response carrying a foreign ID is reported as SLVERR
                resp_q <= (MASTER_WR_BACK_ID == WR_ID) ?
                          MASTER_WR_BACK_RESP : 2'b10;
            end
        end
    end

    // Reset also masks cmd_ready so every handshake output is low in reset
    assign cmd_ready            = rstn && (state == S_IDLE);
    assign wdata_ready          = in_w && MASTER_WR_DATA_READY;
    assign done                 = done_q;
    assign done_resp            = resp_q;
    assign MASTER_WR_ADDR_ID    = WR_ID;
    assign MASTER_WR_ADDR       = addr_q;
    assign MASTER_WR_ADDR_LEN   = len_q;
    assign MASTER_WR_ADDR_BURST = 2'b01;
    assign MASTER_WR_ADDR_VALID = (state == S_AW);
    assign MASTER_WR_DATA       = in_w ? wdata : 32'h0;
    assign MASTER_WR_STRB       = 4'hF;
    assign MASTER_WR_DATA_LAST  = last;
    assign MASTER_WR_DATA_VALID = in_w && wdata_valid;
    assign MASTER_WR_BACK_READY = (state == S_B);

endmodule

// File: tb/tb_axi_wr_master.sv
// Directed bench for axi_wr_master: a table of burst scenarios driven by a
// cycle-level slave model, plus a hand-written mid-burst reset sequence.
module tb_axi_wr_master;

    localparam logic [3:0] ID = 4'h5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_wr_master #(.WR_ID(ID)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_addr             (cmd_addr),
        .cmd_len              (cmd_len),
        .wdata                (wdata),
        .wdata_valid          (wdata_valid),
        .wdata_ready          (wdata_ready),
        .done                 (done),
        .done_resp            (done_resp),
        .MASTER_WR_ADDR_ID    (aw_id),
        .MASTER_WR_ADDR       (aw_addr),
        .MASTER_WR_ADDR_LEN   (aw_len),
        .MASTER_WR_ADDR_BURST (aw_burst),
        .MASTER_WR_ADDR_VALID (aw_valid),
        .MASTER_WR_ADDR_READY (aw_ready),
        .MASTER_WR_DATA       (w_data),
        .MASTER_WR_STRB       (w_strb),
        .MASTER_WR_DATA_LAST  (w_last),
        .MASTER_WR_DATA_VALID (w_valid),
        .MASTER_WR_DATA_READY (w_ready),
        .MASTER_WR_BACK_ID    (b_id),
        .MASTER_WR_BACK_RESP  (b_resp),
        .MASTER_WR_BACK_VALID (b_valid),
        .MASTER_WR_BACK_READY (b_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          aw_dly;
        int          rdy_every;
        int          b_dly;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        bit          spur;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        cmd_addr    = 32'h0;
        cmd_len     = 8'h0;
        wdata       = 32'h0;
        wdata_valid = 1'b0;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        b_id        = 4'h0;
        b_resp      = 2'b00;
        b_valid     = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int  cyc = 0;
        int  b = 0;
        int  bcnt = 0;
        int  awc = 0;
        bit  aw_done = 0;
        bit  last_seen = 0;
        bit  resp_done = 0;
        @(negedge clk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        while (!resp_done) begin
            aw_ready    = (awc >= v.aw_dly);
            w_ready     = ((cyc % v.rdy_every) == v.rdy_every - 1);
            wdata       = 32'hA0 + 32'(b);
            wdata_valid = 1'b1;
            b_id        = v.bid;
            b_resp      = v.bresp;
            b_valid     = last_seen ? (bcnt >= v.b_dly) : v.spur;
            @(negedge clk);
            chk("done_early", {31'b0, done}, 32'd0);
            if (!aw_done) begin
                chk("aw_valid", {31'b0, aw_valid}, 32'd1);
                chk("aw_addr", aw_addr, v.addr);
                chk("aw_len", {24'b0, aw_len}, {24'b0, v.len});
                chk("aw_id", {28'b0, aw_id}, {28'b0, ID});
                chk("aw_burst", {30'b0, aw_burst}, 32'd1);
                chk("w_valid_in_aw", {31'b0, w_valid}, 32'd0);
                chk("b_ready_in_aw", {31'b0, b_ready}, 32'd0);
                if (aw_ready) aw_done = 1;
                awc++;
            end else if (!last_seen) begin
                chk("aw_valid_in_w", {31'b0, aw_valid}, 32'd0);
                chk("w_valid", {31'b0, w_valid}, 32'd1);
                chk("wdata_ready", {31'b0, wdata_ready}, {31'b0, w_ready});
                chk("b_ready_in_w", {31'b0, b_ready}, 32'd0);
                if (w_ready) begin
                    chk("w_data", w_data, 32'hA0 + 32'(b));
                    chk("w_last", {31'b0, w_last},
                        {31'b0, (b == int'(v.len))});
                    chk("w_strb", {28'b0, w_strb}, 32'hF);
                    if (b == int'(v.len)) last_seen = 1;
                    b++;
                end
            end else begin
                chk("w_valid_in_b", {31'b0, w_valid}, 32'd0);
                chk("b_ready", {31'b0, b_ready}, 32'd1);
                if (b_valid) resp_done = 1;
                bcnt++;
            end
            cyc++;
            if (cyc > 2000) begin
                chk("burst_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_resp", {30'b0, done_resp}, {30'b0, v.exp_resp});
        chk("beats", 32'(b), 32'(v.len) + 32'd1);
        chk("b_ready_after", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h10,       8'd3,   0, 1, 0,  ID,   2'b00, 0, 2'b00};
        vecs[1] = '{32'h200,      8'd0,   0, 1, 0,  ID,   2'b00, 0, 2'b00};
        vecs[2] = '{32'h1000,     8'd7,   0, 4, 0,  ID,   2'b00, 0, 2'b00};
        vecs[3] = '{32'h40,       8'd2,   0, 1, 10, ID,   2'b01, 0, 2'b01};
        vecs[4] = '{32'h80,       8'd1,   0, 1, 0,  4'h3, 2'b00, 0, 2'b10};
        vecs[5] = '{32'hFFFFFFF0, 8'd255, 3, 1, 2,  ID,   2'b11, 1, 2'b11};

        idle_inputs();
        rstn = 1'b0;
        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_aw_valid", {31'b0, aw_valid}, 32'd0);
        chk("rst_done_resp", {30'b0, done_resp}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Reset while beat 2 of a six-beat burst is on the bus
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h300;
        cmd_len   = 8'd5;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        aw_ready    = 1'b1;
        w_ready     = 1'b1;
        wdata_valid = 1'b1;
        wdata       = 32'hB0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_w_valid", {31'b0, w_valid}, 32'd1);
        chk("pre_rst_w_last", {31'b0, w_last}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_w_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_w_last", {31'b0, w_last}, 32'd0);
        chk("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
        chk("rst_aw_valid2", {31'b0, aw_valid}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_cmd_ready2", {31'b0, cmd_ready}, 32'd0);
        chk("rst_aw_addr", aw_addr, 32'h0);
        chk("rst_aw_len", {24'b0, aw_len}, 32'd0);
        chk("rst_done_resp2", {30'b0, done_resp}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
            chk("rel_aw_valid", {31'b0, aw_valid}, 32'd0);
            chk("rel_w_valid", {31'b0, w_valid}, 32'd0);
        end
        idle_inputs();
        run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
